// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-lite bus arbiter with burst and lock hold.
// Drives the address-phase and data-phase master selects.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MID_W          = 2
) (
  input  logic                   clk,
  input  logic                   hreset_n,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MID_W-1:0]       hmaster,
  output logic [MID_W-1:0]       hmaster_data,
  output logic                   hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [4:0]       cnt;
  logic [4:0]       cnt_nxt;
  logic [4:0]       len_m1;
  logic [MID_W-1:0] rr_ptr;
  logic [MID_W-1:0] winner;
  logic [MID_W-1:0] idx;
  logic [MID_W-1:0] owner_nxt;
  logic             found;
  logic             arb;

  always_comb begin
    len_m1 = '0;
    unique case (1'b1)
      (hburst == 3'd2 || hburst == 3'd3): len_m1 = 5'd3;
      (hburst == 3'd4 || hburst == 3'd5): len_m1 = 5'd7;
      (hburst == 3'd6 || hburst == 3'd7): len_m1 = 5'd15;
      default:                            len_m1 = '0;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    case (htrans)
      TR_IDLE:   cnt_nxt = '0;
      TR_BUSY:   cnt_nxt = cnt;
      TR_NONSEQ: cnt_nxt = len_m1;
      TR_SEQ:    cnt_nxt = (cnt != '0) ? cnt - 5'd1 : '0;
      default:   cnt_nxt = cnt;
    endcase
  end

  // Scan starts just past the current owner, so the owner comes last.
  always_comb begin
    winner = MID_W'(DEFAULT_MASTER);
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = MID_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!found && hbusreq[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign arb       = hready && !hlock[hmaster] && (cnt_nxt == '0);
  assign owner_nxt = arb ? winner : hmaster;

  always_ff @(posedge clk) begin
    if (!hreset_n) begin
      hgrant       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster      <= MID_W'(DEFAULT_MASTER);
      hmaster_data <= MID_W'(DEFAULT_MASTER);
      hmastlock    <= 1'b0;
      cnt          <= '0;
      rr_ptr       <= MID_W'(DEFAULT_MASTER);
    end else if (hready) begin
      cnt          <= cnt_nxt;
      hmaster_data <= hmaster;
      hmastlock    <= hlock[owner_nxt];
      if (arb) begin
        hgrant  <= NUM_MASTERS'(1) << winner;
        hmaster <= winner;
        rr_ptr  <= winner;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios plus
// random traffic checked against a transaction-level model.
module tb_ahb_bus_arbiter;

  logic       clk;
  logic       hreset_n;
  logic [2:0] hbusreq;
  logic [2:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [2:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_data;
  logic       hmastlock;

  ahb_bus_arbiter #(
    .NUM_MASTERS(3),
    .DEFAULT_MASTER(0),
    .MID_W(2)
  ) dut (
    .clk(clk),
    .hreset_n(hreset_n),
    .hbusreq(hbusreq),
    .hlock(hlock),
    .htrans(htrans),
    .hburst(hburst),
    .hready(hready),
    .hgrant(hgrant),
    .hmaster(hmaster),
    .hmaster_data(hmaster_data),
    .hmastlock(hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_owner = 0;
  int m_data  = 0;
  int m_lock  = 0;
  int m_left  = 0;

  function automatic int beats(input logic [2:0] b);
    if (b >= 3'd6) return 16;
    if (b >= 3'd4) return 8;
    if (b >= 3'd2) return 4;
    return 1;
  endfunction

  function automatic int pick(input logic [2:0] req, input int owner);
    int order[$];
    for (int k = 1; k <= 3; k++) order.push_back((owner + k) % 3);
    foreach (order[j]) if (req[order[j]]) return order[j];
    return 0;
  endfunction

  task automatic step(input logic [2:0] req, input logic [2:0] lk,
                      input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic rst_n);
    int   nl;
    int   nown;
    exp_t e;
    @(negedge clk);
    hbusreq  = req;
    hlock    = lk;
    htrans   = tr;
    hburst   = bu;
    hready   = rdy;
    hreset_n = rst_n;
    if (!rst_n) begin
      m_owner = 0; m_data = 0; m_lock = 0; m_left = 0;
    end else if (rdy) begin
      nl = m_left;
      if (tr == 2'b00) nl = 0;
      else if (tr == 2'b10) nl = beats(bu) - 1;
      else if (tr == 2'b11 && nl > 0) nl = nl - 1;
      nown = m_owner;
      if (!lk[m_owner] && nl == 0) nown = pick(req, m_owner);
      m_data  = m_owner;
      m_owner = nown;
      m_lock  = int'(lk[nown]);
      m_left  = nl;
    end
    e.g  = 3'(1 << m_owner);
    e.m  = 2'(m_owner);
    e.md = 2'(m_data);
    e.l  = m_lock[0];
    q.push_back(e);
  endtask

  task automatic idle(input logic [2:0] req, input int n);
    for (int i = 0; i < n; i++) step(req, 3'b000, 2'b00, 3'd0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    step(3'b000, 3'b000, 2'b00, 3'd0, 1'b1, 1'b0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (hgrant !== e.g) begin
        n_fail++;
        $display("FAIL hgrant t=%0t got %b exp %b", $time, hgrant, e.g);
      end
      n_checks++;
      if (hmaster !== e.m) begin
        n_fail++;
        $display("FAIL hmaster t=%0t got %0d exp %0d", $time, hmaster, e.m);
      end
      n_checks++;
      if (hmaster_data !== e.md) begin
        n_fail++;
        $display("FAIL hmaster_data t=%0t got %0d exp %0d", $time, hmaster_data, e.md);
      end
      n_checks++;
      if (hmastlock !== e.l) begin
        n_fail++;
        $display("FAIL hmastlock t=%0t got %b exp %b", $time, hmastlock, e.l);
      end
    end
  end

  initial begin
    hreset_n = 1'b0;
    hbusreq  = '0;
    hlock    = '0;
    htrans   = '0;
    hburst   = '0;
    hready   = 1'b1;

    // parking with no requests
    do_reset();
    do_reset();
    idle(3'b000, 20);

    // three-way round robin on single beats
    for (int i = 0; i < 9; i++) step(3'b111, 3'b000, 2'b10, 3'd0, 1'b1, 1'b1);

    // INCR4 by M1 while M2 waits
    do_reset();
    idle(3'b010, 1);
    step(3'b110, 3'b000, 2'b10, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b110, 3'b000, 2'b11, 3'd3, 1'b1, 1'b1);
    idle(3'b100, 2);

    // same burst with wait states after beat 2
    do_reset();
    idle(3'b010, 1);
    step(3'b110, 3'b000, 2'b10, 3'd3, 1'b1, 1'b1);
    step(3'b110, 3'b000, 2'b11, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b110, 3'b000, 2'b11, 3'd3, 1'b0, 1'b1);
    step(3'b110, 3'b000, 2'b11, 3'd3, 1'b1, 1'b1);
    step(3'b110, 3'b000, 2'b11, 3'd3, 1'b1, 1'b1);
    idle(3'b100, 2);

    // locked sequence by M2
    do_reset();
    step(3'b100, 3'b100, 2'b00, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b111, 3'b100, 2'b10, 3'd0, 1'b1, 1'b1);
    step(3'b011, 3'b000, 2'b10, 3'd0, 1'b1, 1'b1);
    idle(3'b000, 2);

    // INCR8 cut short by IDLE, then reset mid-burst
    do_reset();
    idle(3'b010, 1);
    step(3'b011, 3'b000, 2'b10, 3'd5, 1'b1, 1'b1);
    step(3'b011, 3'b000, 2'b11, 3'd5, 1'b1, 1'b1);
    step(3'b011, 3'b000, 2'b11, 3'd5, 1'b1, 1'b1);
    step(3'b001, 3'b000, 2'b00, 3'd5, 1'b1, 1'b1);
    idle(3'b010, 1);
    step(3'b110, 3'b000, 2'b10, 3'd7, 1'b1, 1'b1);
    step(3'b110, 3'b000, 2'b11, 3'd7, 1'b1, 1'b1);
    do_reset();
    idle(3'b000, 2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rq;
      logic [2:0] lk;
      logic [1:0] tr;
      logic [2:0] bu;
      logic       rd;
      logic       rs;
      rq = 3'($urandom_range(0, 7));
      lk = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      tr = 2'($urandom_range(0, 3));
      bu = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 4) != 0);
      rs = ($urandom_range(0, 99) != 0);
      step(rq, lk, tr, bu, rd, rs);
    end
    idle(3'b000, 3);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
